// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, mem_arbiter and the shared memory.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_wr_n;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_wr_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr_n, dm_addr, dm_wdata, mem_rdata, mem_rdy,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_wr_n, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wr_n, dm_addr, dm_wdata, mem_rdata, mem_rdy,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_wr_n, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory with registered outputs.
// Optional fetch anti-starvation counter enabled by defining ARB_FAIRNESS_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_mem_en, w_mem_en;
  logic              r_mem_wr_n, w_mem_wr_n;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
  logic              r_lat_wr_n, w_lat_wr_n;
  logic              r_if_ack, w_if_ack;
  logic              r_dm_ack, w_dm_ack;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata;
  logic              r_busy, w_busy;
  logic              w_owe;
  logic              w_dm_grant;
  logic              w_if_grant;

  // A zero limit would let fetch pre-empt every data access.
  if (STARVE_LIMIT == 0) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  assign w_dm_grant = (r_state == IDLE) && bus.dm_req && !w_owe;
  assign w_if_grant = (r_state == IDLE) && bus.if_req && !w_dm_grant;

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] r_starve, w_starve_nxt;

  assign w_owe = bus.if_req && (r_starve == SC_W'(STARVE_LIMIT));

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_if_grant) begin
      w_starve_nxt = '0;
    end else if (w_dm_grant) begin
      w_starve_nxt = bus.if_req ? r_starve + SC_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_starve <= '0;
    else     r_starve <= w_starve_nxt;
  end
`else
  assign w_owe = 1'b0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_en    = 1'b0;
    w_mem_wr_n  = 1'b1;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_lat_wr_n  = r_lat_wr_n;
    w_if_ack    = 1'b0;
    w_dm_ack    = 1'b0;
    w_if_rdata  = r_if_rdata;
    w_dm_rdata  = r_dm_rdata;

    case (r_state)
      IDLE: begin
        if (w_dm_grant) begin
          w_state_nxt = DM_ACC;
          w_mem_en    = 1'b1;
          w_mem_wr_n  = bus.dm_wr_n;
          w_mem_addr  = bus.dm_addr;
          w_mem_wdata = bus.dm_wdata;
          w_lat_wr_n  = bus.dm_wr_n;
        end else if (w_if_grant) begin
          w_state_nxt = IF_ACC;
          w_mem_en    = 1'b1;
          w_mem_addr  = bus.if_addr;
          w_lat_wr_n  = 1'b1;
        end
      end
      IF_ACC: begin
        if (bus.mem_rdy) begin
          w_state_nxt = DONE;
          w_if_ack    = 1'b1;
          w_if_rdata  = bus.mem_rdata;
        end else begin
          w_mem_en    = 1'b1;
        end
      end
      DM_ACC: begin
        if (bus.mem_rdy) begin
          w_state_nxt = DONE;
          w_dm_ack    = 1'b1;
          if (r_lat_wr_n) w_dm_rdata = bus.mem_rdata;
        end else begin
          w_mem_en    = 1'b1;
          w_mem_wr_n  = r_lat_wr_n;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_en    <= 1'b0;
      r_mem_wr_n  <= 1'b1;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_lat_wr_n  <= 1'b1;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_en    <= w_mem_en;
      r_mem_wr_n  <= w_mem_wr_n;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_lat_wr_n  <= w_lat_wr_n;
      r_if_ack    <= w_if_ack;
      r_dm_ack    <= w_dm_ack;
      r_if_rdata  <= w_if_rdata;
      r_dm_rdata  <= w_dm_rdata;
      r_busy      <= w_busy;
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_wr_n  = r_mem_wr_n;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow ARB_FAIRNESS_EN
// the same way the design does.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_ack(input int n);
`ifdef ARB_FAIRNESS_EN
    return (n == 3) ? 2'b10 : 2'b01;
`else
    return 2'b01;
`endif
  endfunction

  initial begin
    int n_acks;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.if_req    = 1'b1;
    bus.if_addr   = 16'h0001;
    bus.dm_req    = 1'b1;
    bus.dm_wr_n   = 1'b0;
    bus.dm_addr   = 16'h0002;
    bus.dm_wdata  = 16'hFFFF;
    bus.mem_rdata = 16'h0000;
    bus.mem_rdy   = 1'b1;

    // Reset held two cycles with both requests active.
    step();
    step();
    check("rst_mem_en",    32'(bus.mem_en),    32'h0);
    check("rst_mem_wr_n",  32'(bus.mem_wr_n),  32'h1);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    check("rst_if_ack",    32'(bus.if_ack),    32'h0);
    check("rst_dm_ack",    32'(bus.dm_ack),    32'h0);
    check("rst_if_rdata",  32'(bus.if_rdata),  32'h0);
    check("rst_dm_rdata",  32'(bus.dm_rdata),  32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);

    // Zero-wait IF read of 0x0010.
    rst           = 1'b0;
    bus.dm_req    = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 16'h0010;
    bus.mem_rdata = 16'hA5A5;
    step();
    check("if_c2_mem_en",   32'(bus.mem_en),   32'h1);
    check("if_c2_mem_addr", 32'(bus.mem_addr), 32'h0010);
    check("if_c2_mem_wr_n", 32'(bus.mem_wr_n), 32'h1);
    check("if_c2_busy",     32'(bus.busy),     32'h1);
    check("if_c2_if_ack",   32'(bus.if_ack),   32'h0);
    step();
    check("if_c3_if_ack",   32'(bus.if_ack),   32'h1);
    check("if_c3_if_rdata", 32'(bus.if_rdata), 32'hA5A5);
    check("if_c3_mem_en",   32'(bus.mem_en),   32'h0);
    bus.if_req = 1'b0;
    step();
    check("if_c4_if_ack",   32'(bus.if_ack),   32'h0);
    check("if_c4_busy",     32'(bus.busy),     32'h0);
    check("if_c4_rdata_hold", 32'(bus.if_rdata), 32'hA5A5);

    // Simultaneous requests: DM store first, then IF.
    bus.if_req    = 1'b1;
    bus.if_addr   = 16'h0030;
    bus.dm_req    = 1'b1;
    bus.dm_wr_n   = 1'b0;
    bus.dm_addr   = 16'h0020;
    bus.dm_wdata  = 16'h1234;
    bus.mem_rdata = 16'h5A5A;
    step();
    check("sim_dm_mem_en",    32'(bus.mem_en),    32'h1);
    check("sim_dm_mem_wr_n",  32'(bus.mem_wr_n),  32'h0);
    check("sim_dm_mem_addr",  32'(bus.mem_addr),  32'h0020);
    check("sim_dm_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
    step();
    check("sim_dm_ack",       32'(bus.dm_ack),    32'h1);
    check("sim_dm_if_ack",    32'(bus.if_ack),    32'h0);
    check("sim_dm_rdata",     32'(bus.dm_rdata),  32'h0);
    bus.dm_req = 1'b0;
    step();
    check("sim_idle_mem_en",  32'(bus.mem_en),    32'h0);
    check("sim_idle_wr_n",    32'(bus.mem_wr_n),  32'h1);
    step();
    check("sim_if_mem_en",    32'(bus.mem_en),    32'h1);
    check("sim_if_mem_addr",  32'(bus.mem_addr),  32'h0030);
    check("sim_if_mem_wr_n",  32'(bus.mem_wr_n),  32'h1);
    check("sim_if_wdata_hold", 32'(bus.mem_wdata), 32'h1234);
    step();
    check("sim_if_ack",       32'(bus.if_ack),    32'h1);
    check("sim_if_rdata",     32'(bus.if_rdata),  32'h5A5A);
    check("sim_if_dm_rdata",  32'(bus.dm_rdata),  32'h0);
    bus.if_req = 1'b0;
    step();
    check("sim_end_busy",     32'(bus.busy),      32'h0);

    // DM load with four wait cycles; request dropped mid-access.
    bus.dm_req    = 1'b1;
    bus.dm_wr_n   = 1'b1;
    bus.dm_addr   = 16'h0040;
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = 16'hBEEF;
    step();
    bus.dm_req  = 1'b0;
    bus.dm_addr = 16'h0099;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("wait%0d_mem_en", k),   32'(bus.mem_en),   32'h1);
      check($sformatf("wait%0d_mem_addr", k), 32'(bus.mem_addr), 32'h0040);
      check($sformatf("wait%0d_mem_wr_n", k), 32'(bus.mem_wr_n), 32'h1);
      check($sformatf("wait%0d_dm_ack", k),   32'(bus.dm_ack),   32'h0);
      bus.mem_rdy = (k == 4);
      if (k == 4) bus.mem_rdata = 16'hBEEF;
      step();
    end
    check("wait_dm_ack",    32'(bus.dm_ack),   32'h1);
    check("wait_dm_rdata",  32'(bus.dm_rdata), 32'hBEEF);
    check("wait_mem_en",    32'(bus.mem_en),   32'h0);
    check("wait_if_rdata",  32'(bus.if_rdata), 32'h5A5A);
    step();
    check("wait_ack_pulse", 32'(bus.dm_ack),   32'h0);
    check("wait_busy",      32'(bus.busy),     32'h0);

    // Both requests held: grant order reflected in the ack sequence.
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0050;
    bus.dm_req  = 1'b1;
    bus.dm_wr_n = 1'b1;
    bus.dm_addr = 16'h0060;
    bus.mem_rdy = 1'b1;
    n_acks = 0;
    for (int c = 0; c < 30 && n_acks < 5; c++) begin
      step();
      if (bus.if_ack || bus.dm_ack) begin
        check($sformatf("order%0d", n_acks), 32'({bus.if_ack, bus.dm_ack}), 32'(exp_ack(n_acks)));
        n_acks++;
      end
    end
    check("order_count", 32'(n_acks), 32'd5);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    step();
    step();
    check("order_busy", 32'(bus.busy), 32'h0);

    // Reset in the middle of a DM access.
    bus.dm_req  = 1'b1;
    bus.dm_addr = 16'h0070;
    bus.mem_rdy = 1'b0;
    step();
    check("abort_mem_en_pre", 32'(bus.mem_en), 32'h1);
    rst = 1'b1;
    step();
    check("abort_mem_en",   32'(bus.mem_en),   32'h0);
    check("abort_dm_ack",   32'(bus.dm_ack),   32'h0);
    check("abort_busy",     32'(bus.busy),     32'h0);
    check("abort_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("abort_dm_rdata", 32'(bus.dm_rdata), 32'h0);
    rst         = 1'b0;
    bus.dm_req  = 1'b0;
    bus.mem_rdy = 1'b1;
    step();
    check("abort_post_ack",  32'(bus.dm_ack), 32'h0);
    check("abort_post_en",   32'(bus.mem_en), 32'h0);
    check("abort_post_busy", 32'(bus.busy),   32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
